// File: rtl/pool_pkg.sv
// Shared constants and FSM encoding for the 2x2 max-pooling controller.
package pool_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/pool_ctrl_max2.sv
// Combinational signed two-input maximum; ties return the common value.
module max2
    import pool_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] a_i,
    input  logic signed [WIDTH-1:0] b_i,
    output logic signed [WIDTH-1:0] y_o
);

    // Direct signed compare: no subtraction, so extreme operands cannot overflow.
    assign y_o = (a_i > b_i) ? a_i : b_i;

endmodule

// File: rtl/pool_ctrl.sv
// 2x2 stride-2 max-pooling controller: horizontal max per pixel pair,
// even-row results parked in a line buffer, odd rows emit the vertical max.
module pool_ctrl
    import pool_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LN = IMG_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic signed [WIDTH-1:0] pix_q;
    logic signed [WIDTH-1:0] out_data_q;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] lbuf_q [LN];
    logic signed [WIDTH-1:0] h_max;
    logic signed [WIDTH-1:0] v_max;
    logic [LW-1:0]           lidx;
    logic                    accept;

    assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
    assign lidx      = LW'(col_q >> 1);

    max2 #(.WIDTH(WIDTH)) u_hmax (
        .a_i (pix_q),
        .b_i (in_data),
        .y_o (h_max)
    );

    max2 #(.WIDTH(WIDTH)) u_vmax (
        .a_i (h_max),
        .b_i (lbuf_q[lidx]),
        .y_o (v_max)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_ONE;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end
            end
            FLUSH: begin
                if (!out_valid_q) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            pix_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (accept && !col_q[0]) begin
                pix_q <= in_data;
            end
            if (accept && col_q[0] && row_q[0]) begin
                out_valid_q <= 1'b1;
                out_data_q  <= v_max;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffer holds even-row pair maxima; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && !row_q[0]) begin
            lbuf_q[lidx] <= h_max;
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// Directed bench for pool_ctrl: 4x2 frame table plus 4x4 ramp and reset-abort sequences.
module tb_pool_ctrl;

    localparam int W = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                start, in_valid, out_ready;
    logic signed [W-1:0] in_data;
    logic                in_ready, out_valid, busy, done;
    logic signed [W-1:0] out_data;

    logic                q_start, q_in_valid, q_out_ready;
    logic signed [W-1:0] q_in_data;
    logic                q_in_ready, q_out_valid, q_busy, q_done;
    logic signed [W-1:0] q_out_data;

    pool_ctrl #(.WIDTH(W), .IMG_W(4), .IMG_H(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    pool_ctrl #(.WIDTH(W), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (q_start),
        .in_valid  (q_in_valid),
        .in_data   (q_in_data),
        .in_ready  (q_in_ready),
        .out_valid (q_out_valid),
        .out_data  (q_out_data),
        .out_ready (q_out_ready),
        .busy      (q_busy),
        .done      (q_done)
    );

    typedef struct packed {
        logic [8*W-1:0] px;
        logic [W-1:0]   e0;
        logic [W-1:0]   e1;
        logic [1:0]     mode;
    } vec_t;

    vec_t vt [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input integer act, input integer exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [8*W-1:0] pack8(input int a0, input int a1,
                                             input int a2, input int a3,
                                             input int a4, input int a5,
                                             input int a6, input int a7);
        return {W'(a7), W'(a6), W'(a5), W'(a4),
                W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    // mode 0: continuous, 1: in_valid every other cycle, 2: 5-cycle output stall
    task automatic run_frame(input int idx);
        vec_t v;
        int p, got, cyc, stall, last_c;
        bit dn;
        v = vt[idx];
        p = 0; got = 0; cyc = 0; stall = 0; last_c = -10; dn = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!dn && cyc < 100) begin
            in_valid  = (p < 8) && (v.mode != 2'd1 || cyc % 2 == 0);
            in_data   = (p < 8) ? v.px[p*W +: W] : '0;
            out_ready = !(v.mode == 2'd2 && out_valid && stall < 5);
            if (!out_ready) stall++;
            #1;
            if (cyc == 0) chk("busy_run", busy, 1);
            if (!out_ready) begin
                chk("stall_hold", $signed(out_data), $signed(v.e0));
                chk("stall_inrdy", in_ready, 0);
            end
            if (in_valid && in_ready) p++;
            if (out_valid && out_ready) begin
                if (got == 0) chk("out0", $signed(out_data), $signed(v.e0));
                else if (got == 1) chk("out1", $signed(out_data), $signed(v.e1));
                else chk("extra_out", got, 1);
                got++;
                last_c = cyc;
            end
            if (done) begin
                dn = 1'b1;
                chk("done_lat", cyc, last_c + 1);
                chk("out_count", got, 2);
                chk("pix_count", p, 8);
            end
            cyc++;
            @(negedge clk);
        end
        if (!dn) chk("done_timeout", 0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int p, got, cyc, dones;
        bit dn;
        int e4 [4];

        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        q_start = 1'b0; q_in_valid = 1'b0; q_in_data = '0; q_out_ready = 1'b1;

        vt[0] = '{pack8(1, 5, -3, 2, 4, 0, 7, -8), W'(5), W'(7), 2'd0};
        vt[1] = '{pack8(-256, 255, -256, -256, -256, -256, 255, -256),
                  W'(255), W'(255), 2'd0};
        vt[2] = '{pack8(1, 5, -3, 2, 4, 0, 7, -8), W'(5), W'(7), 2'd2};
        vt[3] = '{pack8(1, 5, -3, 2, 4, 0, 7, -8), W'(5), W'(7), 2'd1};
        vt[4] = '{pack8(3, 3, -1, -1, 3, 3, -1, -1), W'(3), W'(-1), 2'd0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", $signed(out_data), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst4_busy", q_busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_frame(i);

        // Abort after 5 accepted pixels, then a clean frame must still pool correctly.
        p = 0; cyc = 0; dones = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (p < 5 && cyc < 50) begin
            in_valid = 1'b1;
            in_data  = vt[0].px[p*W +: W];
            #1;
            if (in_valid && in_ready) p++;
            if (done) dones++;
            cyc++;
            @(negedge clk);
        end
        chk("abort_pix", p, 5);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        #1;
        if (done) dones++;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        if (done) dones++;
        chk("abort_no_done", dones, 0);
        run_frame(0);

        // 4x4 ramp; start pulses mid-frame and during FLUSH/done must be ignored.
        e4 = '{5, 7, 13, 15};
        p = 0; got = 0; cyc = 0; dn = 1'b0;
        @(negedge clk);
        q_start = 1'b1;
        @(negedge clk);
        q_start = 1'b0;
        while (!dn && cyc < 200) begin
            q_in_valid  = (p < 16);
            q_in_data   = W'(p);
            q_start     = (p == 6) || (p == 16);
            q_out_ready = 1'b1;
            #1;
            if (q_in_valid && q_in_ready) p++;
            if (q_out_valid) begin
                if (got < 4) chk("ramp_out", $signed(q_out_data), e4[got]);
                else chk("ramp_extra", got, 3);
                got++;
            end
            if (q_done) begin
                dn = 1'b1;
                chk("ramp_count", got, 4);
                chk("ramp_pix", p, 16);
            end
            cyc++;
            @(negedge clk);
        end
        if (!dn) chk("ramp_timeout", 0, 1);
        q_start    = 1'b0;
        q_in_valid = 1'b0;
        #1;
        chk("ramp_idle_busy", q_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
